sccb_write_arbiter: RTL and testbench
=====================================

// Module: sccb_write_arbiter
// PURPOSE
//  Shares the single i2c_top SCCB master between NUM_REQ register-write requesters, e.g. init sequencer and key-driven brightness/contrast/threshold control.
//  Grants round-robin, then runs the full 3-phase write: slave addr, reg addr, reg data, stop.
//  Enforces an inter-transaction gap, ack timeout and NACK reporting, so requesters never drive i2c_top directly.
// PARAMETERS
//  NUM_REQ        2        number of requesters (1..8)
//  SLAVE_ADDR     8'h42    SCCB write address sent in phase 1 (OV7670)
//  GAP_CYCLES     65536    idle clk_100 cycles after stop before next start (~0.66 ms)
//  TIMEOUT_CYCLES 262144   max cycles waiting for any ack tick before abort
//  MAX_RETRY      3        retries per request (used only with SCCB_RETRY_EN)
// PORTS
//  clk_100      in   1          system clock; the only clock
//  rst_n        in   1          asynchronous active-low reset
//  req_valid    in   NUM_REQ    per-requester write request, held until its req_done
//  req_addr     in   8*NUM_REQ  register address, slice i for requester i
//  req_data     in   8*NUM_REQ  register data, slice i for requester i
//  req_done     out  NUM_REQ    1-cycle pulse: granted request finished (ok or error)
//  req_err      out  NUM_REQ    1-cycle pulse coincident with req_done on NACK/timeout
//  grant        out  NUM_REQ    one-hot owner of the bus; 0 when idle
//  busy         out  1          high from grant until GAP expires
//  i2c_start    out  1          start strobe to i2c_top
//  i2c_stop     out  1          stop strobe to i2c_top
//  i2c_wr_data  out  8          byte to i2c_top
//  i2c_ack      in   2          from i2c_top: [1] ack-bit tick, [0] 1=ACK 0=NACK
//  i2c_state    in   4          i2c_top state; 0 = idle
// BEHAVIOUR
//  Reset: all outputs 0. FSM=IDLE. RR pointer=NUM_REQ-1, so req 0 wins first.
//  Reset mid-transaction: abort immediately; no req_done/req_err issued.
//  States: IDLE, START, ADDR, DATA, STOP, GAP.
//  IDLE: if |req_valid and i2c_state==0, pick first valid index after pointer, cyclically.
//    Latch that requester's addr/data, set grant/busy, update pointer -> START next cycle.
//    req_valid low after grant does not cancel; latched values are used.
//  START: i2c_start=1, i2c_wr_data=SLAVE_ADDR for exactly 1 cycle -> ADDR.
//  ADDR: on i2c_ack==2'b11, same cycle i2c_wr_data=latched addr -> DATA.
//  DATA: on i2c_ack==2'b11, same cycle i2c_wr_data=latched data -> STOP.
//  STOP: on i2c_ack==2'b11, same cycle i2c_stop=1 -> GAP.
//    req_done[g] pulses next cycle.
//  i2c_start, i2c_stop, i2c_wr_data: combinational from state+i2c_ack, 0 otherwise.
//    i2c_top samples them in the ack cycle.
//  NACK (i2c_ack==2'b10) in ADDR/DATA/STOP: i2c_stop=1 same cycle -> GAP.
//    req_done[g] and req_err[g] pulse next cycle.
//  Timeout: counter clears on entering ADDR and on every i2c_ack[1].
//    Reaching TIMEOUT_CYCLES in ADDR/DATA/STOP: i2c_stop=1 -> GAP, done+err as for NACK.
//  GAP: count GAP_CYCLES; grant cleared on entry.
//    At end, busy=0 -> IDLE. Re-arbitrate same cycle if requests pending.
//  Fairness: requester still valid after its req_done ranks last vs others.
//  i2c_state!=0 in IDLE: hold IDLE, no grant.
// CONFIGURATION
//  SCCB_RETRY_EN defined: NACK/timeout -> stop, GAP, then START again with the same grant.
//    No done/err pulse until success, or until MAX_RETRY retries all fail (then done+err).
//  SCCB_RETRY_EN undefined: first NACK/timeout ends the request with done+err; no retry logic.
// TESTING (bench: i2c_top ack model, GAP_CYCLES=16, TIMEOUT_CYCLES=64)
//  req_valid=01, addr0=8'h55, data0=8'h10, all ACK ->
//    wr_data 42,55,10; stop; req_done=01 1 cycle; busy low 16 cycles after stop.
//  req_valid=11 held through 4 transactions -> grant order 01,10,01,10; no start during GAP.
//  NACK on data byte, macro off -> stop same cycle, req_done=req_err=01 next cycle.
//    Macro on -> 4 attempts, then done+err.
//  No ack for 64 cycles in ADDR -> i2c_stop=1, req_err pulse, FSM reaches IDLE after gap.
//  rst_n low during DATA -> outputs 0 asynchronously, no done.
//    After release, req 0 re-served from START.
//  i2c_state=3 with req_valid=01 -> no grant until i2c_state=0, then START next cycle.

Source files
------------

// File: rtl/sccb_write_arbiter_if.sv
// Requester and i2c_top side signals of the SCCB write arbiter.
// master: the arbiter; slave: requesters plus the i2c_top master.
interface sccb_write_arbiter_if #(
  parameter int NUM_REQ = 2
) ();
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_addr;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_done;
  logic [NUM_REQ-1:0]   req_err;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;
  logic                 i2c_start;
  logic                 i2c_stop;
  logic [7:0]           i2c_wr_data;
  logic [1:0]           i2c_ack;
  logic [3:0]           i2c_state;

  modport master (
    input  req_valid, req_addr, req_data,
    input  i2c_ack, i2c_state,
    output req_done, req_err, grant, busy,
    output i2c_start, i2c_stop, i2c_wr_data
  );

  modport slave (
    output req_valid, req_addr, req_data,
    output i2c_ack, i2c_state,
    input  req_done, req_err, grant, busy,
    input  i2c_start, i2c_stop, i2c_wr_data
  );
endinterface

// File: rtl/sccb_write_arbiter.sv
// Round-robin SCCB register-write arbiter in front of i2c_top.
// Define SCCB_RETRY_EN to retry NACK/timeout up to MAX_RETRY times.
module sccb_write_arbiter #(
  parameter int         NUM_REQ        = 2,
  parameter logic [7:0] SLAVE_ADDR     = 8'h42,
  parameter int         GAP_CYCLES     = 65536,
  parameter int         TIMEOUT_CYCLES = 262144,
  parameter int         MAX_RETRY      = 3
) (
  input logic clk_100,
  input logic rst_n,
  sccb_write_arbiter_if.master bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_DATA, S_STOP, S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic               busy_q, busy_d;
  logic [7:0]         addr_q, addr_d;
  logic [7:0]         data_q, data_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic [GW-1:0]      gap_q, gap_d;
`ifdef SCCB_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;
  logic [RW-1:0]      rty_q, rty_d;
  logic               again_q, again_d;
`endif

  logic          start_c, stop_c, arb_c, fail_c;
  logic [7:0]    wr_c;
  logic          pick_ok;
  logic [PW-1:0] pick_idx;
  logic [PW:0]   j;

  // Smallest offset after the pointer wins, so it is assigned last.
  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = ptr_q;
    j        = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = {1'b0, ptr_q} + (PW+1)'(k);
      if (j >= (PW+1)'(NUM_REQ))
        j = j - (PW+1)'(NUM_REQ);
      if (bus.req_valid[j[PW-1:0]]) begin
        pick_ok  = 1'b1;
        pick_idx = j[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    addr_d  = addr_q;
    data_d  = data_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    done_d  = '0;
    err_d   = '0;
    start_c = 1'b0;
    stop_c  = 1'b0;
    wr_c    = 8'h00;
    arb_c   = 1'b0;
    fail_c  = 1'b0;
`ifdef SCCB_RETRY_EN
    rty_d   = rty_q;
    again_d = again_q;
`endif
    unique case (state_q)
      S_IDLE: arb_c = 1'b1;
      S_START: begin
        start_c = 1'b1;
        wr_c    = SLAVE_ADDR;
        tmo_d   = '0;
        state_d = S_ADDR;
      end
      S_ADDR, S_DATA, S_STOP: begin
        tmo_d = bus.i2c_ack[1] ? '0 : tmo_q + TW'(1);
        if (bus.i2c_ack == 2'b11) begin
          unique case (state_q)
            S_ADDR: begin
              wr_c    = addr_q;
              state_d = S_DATA;
            end
            S_DATA: begin
              wr_c    = data_q;
              state_d = S_STOP;
            end
            default: begin
              stop_c  = 1'b1;
              done_d  = grant_q;
              grant_d = '0;
              gap_d   = '0;
              state_d = S_GAP;
`ifdef SCCB_RETRY_EN
              rty_d   = '0;
`endif
            end
          endcase
        end else if (bus.i2c_ack == 2'b10 ||
                     tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          stop_c = 1'b1;
          fail_c = 1'b1;
        end
      end
      S_GAP: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
`ifdef SCCB_RETRY_EN
          if (again_q) begin
            again_d = 1'b0;
            state_d = S_START;
          end else begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
            arb_c   = 1'b1;
          end
`else
          busy_d  = 1'b0;
          state_d = S_IDLE;
          arb_c   = 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fail_c) begin
      state_d = S_GAP;
      gap_d   = '0;
`ifdef SCCB_RETRY_EN
      if (rty_q < RW'(MAX_RETRY)) begin
        rty_d   = rty_q + RW'(1);
        again_d = 1'b1;
      end else begin
        rty_d   = '0;
        done_d  = grant_q;
        err_d   = grant_q;
        grant_d = '0;
      end
`else
      done_d  = grant_q;
      err_d   = grant_q;
      grant_d = '0;
`endif
    end

    if (arb_c && pick_ok && bus.i2c_state == 4'd0) begin
      grant_d = NUM_REQ'(1) << pick_idx;
      busy_d  = 1'b1;
      ptr_d   = pick_idx;
      addr_d  = bus.req_addr[int'(pick_idx)*8 +: 8];
      data_d  = bus.req_data[int'(pick_idx)*8 +: 8];
      state_d = S_START;
    end
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= PW'(NUM_REQ - 1);
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      tmo_q   <= '0;
      gap_q   <= '0;
`ifdef SCCB_RETRY_EN
      rty_q   <= '0;
      again_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
`ifdef SCCB_RETRY_EN
      rty_q   <= rty_d;
      again_q <= again_d;
`endif
    end
  end

  assign bus.i2c_start   = start_c;
  assign bus.i2c_stop    = stop_c;
  assign bus.i2c_wr_data = wr_c;
  assign bus.req_done    = done_q;
  assign bus.req_err     = err_q;
  assign bus.grant       = grant_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_sccb_write_arbiter.sv
// Scoreboard bench for sccb_write_arbiter with an i2c_top ack model.
// GAP_CYCLES=16, TIMEOUT_CYCLES=64; follows SCCB_RETRY_EN if defined.
module tb_sccb_write_arbiter;
  localparam int N = 2;
`ifdef SCCB_RETRY_EN
  localparam int ATTEMPTS = 4;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sccb_write_arbiter_if #(.NUM_REQ(N)) bus ();

  sccb_write_arbiter #(
    .NUM_REQ(N),
    .SLAVE_ADDR(8'h42),
    .GAP_CYCLES(16),
    .TIMEOUT_CYCLES(64),
    .MAX_RETRY(3)
  ) dut (
    .clk_100(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef enum int {K_START, K_ACK, K_STOP, K_DONE} kind_e;
  typedef struct {
    kind_e       k;
    logic [15:0] v;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  failures = 0;

  function automatic void push(kind_e k, logic [15:0] v);
    ev_t e;
    e.k = k;
    e.v = v;
    q.push_back(e);
  endfunction

  function automatic void check(string nm, logic [31:0] act,
                                logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endfunction

  function automatic void sb(kind_e k, logic [15:0] v);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL sb_unexpected actual=%0d/%h required=none",
               k, v);
    end else begin
      e = q.pop_front();
      if (e.k != k || e.v !== v) begin
        failures++;
        $display("FAIL sb_event actual=%0d/%h required=%0d/%h",
                 k, v, e.k, e.v);
      end
    end
  endfunction

  // Monitor: every strobe the DUT presents is matched against the queue.
  always @(negedge clk) begin
    if (bus.i2c_start)
      sb(K_START, {6'b0, bus.grant, bus.i2c_wr_data});
    if (bus.i2c_ack[1])
      sb(K_ACK, {7'b0, bus.i2c_stop, bus.i2c_wr_data});
    else if (bus.i2c_stop)
      sb(K_STOP, {7'b0, bus.i2c_stop, bus.i2c_wr_data});
    if (|bus.req_done || |bus.req_err)
      sb(K_DONE, {6'b0, bus.req_done, 6'b0, bus.req_err});
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  task automatic ack(input logic [1:0] a, input int dly);
    repeat (dly) @(posedge clk);
    #1 bus.i2c_ack = a;
    @(posedge clk);
    #1 bus.i2c_ack = 2'b00;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (bus.i2c_start) begin
        n = i;
        break;
      end
    end
    if (n == 0) begin
      checks++;
      failures++;
      $display("FAIL wait_start actual=none required=start");
    end
  endtask

  task automatic wait_idle();
    int ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1;
        break;
      end
    end
    check("idle_reached", ok, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus.i2c_ack = 2'b00;
    bus.i2c_state = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic good_txn(input logic [1:0] g, input logic [7:0] a,
                          input logic [7:0] d, output int n);
    push(K_START, {6'b0, g, 8'h42});
    push(K_ACK, {8'h00, a});
    push(K_ACK, {8'h00, d});
    push(K_ACK, 16'h0100);
    push(K_DONE, {6'b0, g, 8'h00});
    wait_start(n);
    ack(2'b11, 1);
    ack(2'b11, 2);
    ack(2'b11, 3);
  endtask

  initial begin
    int n;
    int cnt;
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus.i2c_ack = 2'b00;
    bus.i2c_state = 4'd0;
    #2;
    check("reset_outputs", {bus.grant, bus.busy, bus.i2c_start,
          bus.i2c_stop, bus.i2c_wr_data, bus.req_done,
          bus.req_err}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {bus.grant, bus.busy}, 0);

    // single write from requester 0, all ACK
    bus.req_valid = 2'b01;
    bus.req_addr = 16'h0055;
    bus.req_data = 16'h0010;
    good_txn(2'b01, 8'h55, 8'h10, n);
    bus.req_valid = '0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("t1_done_pulse", {bus.req_done, bus.req_err}, 4'b0100);
        check("t1_grant_cleared", bus.grant, 0);
      end
      if (!bus.busy) break;
      cnt++;
    end
    check("t1_busy_gap", cnt, 16);
    @(negedge clk);
    check("t1_done_one_cycle", bus.req_done, 0);

    // both requesters held: alternate grants, gap before each start
    do_reset();
    bus.req_valid = 2'b11;
    bus.req_addr = 16'h6655;
    bus.req_data = 16'h2010;
    good_txn(2'b01, 8'h55, 8'h10, n);
    check("t2_first_latency", n, 2);
    good_txn(2'b10, 8'h66, 8'h20, n);
    check("t2_gap_start_2", n, 17);
    good_txn(2'b01, 8'h55, 8'h10, n);
    check("t2_gap_start_3", n, 17);
    good_txn(2'b10, 8'h66, 8'h20, n);
    check("t2_gap_start_4", n, 17);
    bus.req_valid = '0;
    wait_idle();

    // NACK on the data byte
    do_reset();
    bus.req_valid = 2'b01;
    bus.req_addr = 16'h0055;
    bus.req_data = 16'h0010;
    for (int a = 0; a < ATTEMPTS; a++) begin
      push(K_START, 16'h0142);
      push(K_ACK, 16'h0055);
      push(K_ACK, 16'h0100);
      if (a == ATTEMPTS - 1)
        push(K_DONE, 16'h0101);
      wait_start(n);
      if (a > 0) check("t3_retry_gap", n, 17);
      ack(2'b11, 1);
      ack(2'b10, 2);
    end
    @(negedge clk);
    check("t3_done_err", {bus.req_done, bus.req_err}, 4'b0101);
    bus.req_valid = '0;
    wait_idle();

    // no ack at all in ADDR: timeout
    do_reset();
    bus.req_valid = 2'b01;
    bus.req_addr = 16'h0055;
    bus.req_data = 16'h0010;
    for (int a = 0; a < ATTEMPTS; a++) begin
      push(K_START, 16'h0142);
      push(K_STOP, 16'h0100);
      if (a == ATTEMPTS - 1)
        push(K_DONE, 16'h0101);
      wait_start(n);
      cnt = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        cnt++;
        if (bus.i2c_stop) break;
      end
      check("t4_timeout_cycles", cnt, 64);
    end
    @(negedge clk);
    check("t4_done_err", {bus.req_done, bus.req_err}, 4'b0101);
    bus.req_valid = '0;
    wait_idle();
    check("t4_idle_grant", bus.grant, 0);

    // asynchronous reset while in DATA
    do_reset();
    bus.req_valid = 2'b01;
    bus.req_addr = 16'h0077;
    bus.req_data = 16'h0033;
    push(K_START, 16'h0142);
    push(K_ACK, 16'h0077);
    wait_start(n);
    ack(2'b11, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_reset", {bus.grant, bus.busy, bus.i2c_start,
          bus.i2c_stop, bus.i2c_wr_data, bus.req_done,
          bus.req_err}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    good_txn(2'b01, 8'h77, 8'h33, n);
    check("t5_restart_latency", n, 2);
    bus.req_valid = '0;
    wait_idle();

    // i2c_top not idle: hold off arbitration
    do_reset();
    bus.i2c_state = 4'd3;
    bus.req_valid = 2'b01;
    bus.req_addr = 16'h0055;
    bus.req_data = 16'h0010;
    repeat (10) @(negedge clk);
    check("t6_no_grant", {bus.grant, bus.busy}, 0);
    @(posedge clk);
    #1 bus.i2c_state = 4'd0;
    good_txn(2'b01, 8'h55, 8'h10, n);
    check("t6_start_latency", n, 2);
    bus.req_valid = '0;
    wait_idle();

    repeat (5) @(negedge clk);
    check("sb_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
